spi_target_ht16d35a_rx: RTL
===========================

// Module: spi_target_ht16d35a_rx
// PURPOSE
//  Receive side of the HT16D35A-style 3-wire SPI link: an oversampling target that deserialises
//  dio on rising sck (CPOL=1, MSB first) while cs is low. Emits one byte pulse per 8 bits, checks
//  the 2us inter-byte sck-high gap, and reports a per-frame summary on cs release. It acts as a
//  loopback checker for the SPI controller and as the front end for a panel/display model.
// PARAMETERS
//  SYNC_STAGES  2    flops per synchroniser on sck/dio/cs (>=2)
//  CLK_2us      100  clk cycles in 2us (50 MHz); minimum legal inter-byte sck-high time
//  us2_SZ       $clog2(CLK_2us+1)  gap counter width
//  MAX_BYTES    8    bytes accepted per frame; extra bytes are dropped and flagged
//  BYTES_SZ     $clog2(MAX_BYTES+1)  frame byte-count width
// PORTS
//  clk          in   1         system clock; the only clock
//  reset        in   1         asynchronous, active-low reset
//  sck          in   1         SPI clock from the controller (idles high); asynchronous to clk
//  dio          in   1         SPI data; this block never drives it
//  cs           in   1         chip select, active low
//  rx_data      out  8         received byte; valid only while rx_valid=1
//  rx_valid     out  1         1-cycle pulse per complete byte
//  rx_first     out  1         qualifies rx_valid: first byte of the frame
//  frame_done   out  1         1-cycle pulse after cs deasserts (synchronised rising edge)
//  frame_bytes  out  BYTES_SZ  bytes emitted in the frame; held until the next frame_done
//  err_partial  out  1         frame ended mid-byte; held with frame_bytes
//  err_gap      out  1         an inter-byte gap was shorter than CLK_2us; held
//  err_overflow out  1         more than MAX_BYTES bytes were received; held
//  busy         out  1         1 from cs fall (synchronised) until frame_done
// BEHAVIOUR
//  - Reset: all outputs are 0, state=IDLE, counters=0, armed=0. Synchroniser flops reset to 1
//    for sck/cs and 0 for dio.
//  - armed is set once synced cs=1; a cs fall is accepted only when armed. Reset mid-frame
//    therefore ignores the rest of that frame.
//  - Edges come from synced signals (prev vs current). dio uses the same depth, so it is sampled
//    in the cycle sck_rise is detected.
//  - States: IDLE -> (cs_fall & armed) -> BITS. BITS -> 8th sck_rise -> GAP. GAP -> sck_fall -> BITS.
//    Any state -> cs_rise -> IDLE.
//  - On cs_fall: bit_cnt, byte_cnt and all err_* clear; busy=1. A later cs_fall restarts
//    cleanly.
//  - BITS: on each sck_rise, shreg={shreg[6:0],dio} and bit_cnt++. On the 8th sck_rise, emit
//    the byte (registered) if byte_cnt<MAX_BYTES; otherwise set err_overflow and emit nothing.
//  - rx_valid latency: 1 clk after the sck_rise detection cycle, i.e. SYNC_STAGES+2 clk after
//    the pin edge. rx_first=1 only for byte_cnt==0.
//  - GAP: gap_cnt counts every clk from the 8th sck_rise and saturates at CLK_2us. If the next
//    sck_fall arrives with gap_cnt<CLK_2us, err_gap sets; the following byte is still received.
//  - cs_rise in BITS with bit_cnt!=0 sets err_partial and discards the partial byte. In the next
//    cycle: frame_done=1, busy=0, frame_bytes=byte_cnt (saturates at MAX_BYTES).
//  - Same-cycle cs_rise and sck_rise: cs_rise wins and the sck edge is ignored.
//  - sck_rise/sck_fall while IDLE or cs high: ignored. sck low at cs_fall: legal, but the first
//    sck_fall does not count as a bit.
//  - Minimum legal sck half-period: >= SYNC_STAGES+1 clk (CLK_DIV=16 is fine).
// STRUCTURE
//  - Package spi_ht16d35a_pkg holds the rx_state_t enum {IDLE,BITS,GAP}, a rx_err_t struct
//    {partial,gap,overflow}, and localparams SPI_BITS=8 and SCK_IDLE=1'b1. This package is
//    shared with the controller.
//  - Sub-module spi_sync_edge (param STAGES, RESET_VAL) provides the synchroniser, rise and fall
//    outputs; it is instantiated for sck, cs and dio (dio uses only the level output).
//  - The top level holds the FSM, shift register, bit/byte/gap counters and output registers.
// TESTING
//  - 3-byte frame A5,3C,FF with 2.4us gaps (CLK_DIV=16) -> rx_valid x3, data A5,3C,FF,
//    rx_first on A5 only; frame_done with frame_bytes=3 and all err=0.
//  - 2-byte frame with a 1.0us gap -> both bytes emitted, err_gap=1 at frame_done,
//    err_partial=0.
//  - cs rises after 5 bits of the 2nd byte -> 1 byte emitted, frame_bytes=1, err_partial=1.
//  - 10-byte frame with MAX_BYTES=8 -> 8 rx_valid pulses, frame_bytes=8, err_overflow=1.
//  - reset low for 3 clk in the middle of byte 2, then release with cs still low -> no
//    rx_valid and no frame_done until cs goes high; the next frame (byte 81) is received
//    normally.
//  - cs rise driven in the same synced cycle as the 8th sck rise -> no rx_valid for that byte,
//    err_partial=1.

Source files
------------

// File: rtl/spi_ht16d35a_pkg.sv
// Shared types and constants for the HT16D35A-style 3-wire SPI controller and target.
package spi_ht16d35a_pkg;

    localparam int   SPI_BITS = 8;
    localparam logic SCK_IDLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        GAP  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic partial;
        logic gap;
        logic overflow;
    } rx_err_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall strobes derived
// from the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_target_ht16d35a_rx.sv
// Oversampling SPI receive target (CPOL=1, MSB first): byte strobes, inter-byte gap
// checking and a per-frame summary on chip-select release.
module spi_target_ht16d35a_rx
    import spi_ht16d35a_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CLK_2us     = 100,
    parameter int us2_SZ      = $clog2(CLK_2us + 1),
    parameter int MAX_BYTES   = 8,
    parameter int BYTES_SZ    = $clog2(MAX_BYTES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                dio,
    input  logic                cs,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                rx_first,
    output logic                frame_done,
    output logic [BYTES_SZ-1:0] frame_bytes,
    output logic                err_partial,
    output logic                err_gap,
    output logic                err_overflow,
    output logic                busy
);

    localparam int                BIT_W    = $clog2(SPI_BITS);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(SPI_BITS - 1);
    localparam int                SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic w_sck_rise, w_sck_fall, w_unused_sck_level;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_dio, w_unused_dio_rise, w_unused_dio_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sync_sck (
        .clk(clk), .reset(reset), .i_async(sck),
        .o_level(w_unused_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .i_async(cs),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dio (
        .clk(clk), .reset(reset), .i_async(dio),
        .o_level(w_dio), .o_rise(w_unused_dio_rise), .o_fall(w_unused_dio_fall)
    );

    rx_state_t             r_state, w_state_next;
    logic [SETTLE_W-1:0]   r_settle;
    logic                  r_armed;
    logic [SPI_BITS-2:0]   r_shreg;
    logic [SPI_BITS-1:0]   w_shreg_next;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [BYTES_SZ-1:0]   r_byte_cnt;
    logic [us2_SZ-1:0]     r_gap_cnt;
    logic [SPI_BITS-1:0]   r_rx_data;
    logic                  r_rx_valid, r_rx_first, r_frame_done, r_busy;
    logic [BYTES_SZ-1:0]   r_frame_bytes;
    rx_err_t               r_err;

    assign w_shreg_next = {r_shreg, w_dio};

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic; a cs release beats any simultaneous sck edge
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_state_next = BITS;
                end else begin
                    w_state_next = IDLE;
                end
            end
            BITS: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                end else if (w_sck_rise && (r_bit_cnt == LAST_BIT)) begin
                    w_state_next = GAP;
                end else begin
                    w_state_next = BITS;
                end
            end
            GAP: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                end else if (w_sck_fall) begin
                    w_state_next = BITS;
                end else begin
                    w_state_next = GAP;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Arm only once the cs synchroniser holds real pin samples, so the reset value
    // flushing out cannot fake a cs fall in the middle of a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != SETTLE_W'(SYNC_STAGES)) begin
                r_settle <= r_settle + SETTLE_W'(1);
            end
            if ((r_settle == SETTLE_W'(SYNC_STAGES)) && w_cs_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    // shift register, counters, error flags and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_first    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_bytes <= '0;
            r_busy        <= 1'b0;
            r_err         <= '0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_cs_rise && (r_state != IDLE)) begin
                if ((r_state == BITS) && (r_bit_cnt != '0)) begin
                    r_err.partial <= 1'b1;
                end
                r_bit_cnt     <= '0;
                r_frame_done  <= 1'b1;
                r_busy        <= 1'b0;
                r_frame_bytes <= r_byte_cnt;
            end else if (w_cs_fall && r_armed && (r_state == IDLE)) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_err      <= '0;
                r_busy     <= 1'b1;
            end else if ((r_state == BITS) && w_sck_rise) begin
                r_shreg <= w_shreg_next[SPI_BITS-2:0];
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt <= '0;
                    r_gap_cnt <= '0;
                    if (r_byte_cnt < BYTES_SZ'(MAX_BYTES)) begin
                        r_rx_data  <= w_shreg_next;
                        r_rx_valid <= 1'b1;
                        r_rx_first <= (r_byte_cnt == '0);
                        r_byte_cnt <= r_byte_cnt + BYTES_SZ'(1);
                    end else begin
                        r_err.overflow <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                end
            end else if (r_state == GAP) begin
                if (w_sck_fall && (r_gap_cnt < us2_SZ'(CLK_2us))) begin
                    r_err.gap <= 1'b1;
                end
                if (r_gap_cnt < us2_SZ'(CLK_2us)) begin
                    r_gap_cnt <= r_gap_cnt + us2_SZ'(1);
                end
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_first     = r_rx_first;
    assign frame_done   = r_frame_done;
    assign frame_bytes  = r_frame_bytes;
    assign err_partial  = r_err.partial;
    assign err_gap      = r_err.gap;
    assign err_overflow = r_err.overflow;
    assign busy         = r_busy;

endmodule
